// File: rtl/ahb_iopmp_cfg_seq.sv
// AHB-lite write sequencer that programs one IOPMP region per command:
// optional ctrl disable, base, mask, then ctrl with the final enable.
// Keeps shadow copies of both ctrl enable bytes because the config port
// is write-posted and cannot be read back cheaply.
module ahb_iopmp_cfg_seq #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] CFG_BASE   = '0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_port,
  input  logic [2:0]            cmd_idx,
  input  logic [31:0]           cmd_base,
  input  logic [31:0]           cmd_mask,
  input  logic                  cmd_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            en_0,
  output logic [7:0]            en_1,
  output logic                  m_hsel,
  output logic [ADDR_WIDTH-1:0] m_haddr,
  output logic [3:0]            m_hprot,
  output logic [2:0]            m_hsize,
  output logic [1:0]            m_htrans,
  output logic [2:0]            m_hburst,
  output logic                  m_hwrite,
  output logic [DATA_WIDTH-1:0] m_hwdata,
  input  logic [1:0]            m_hresp,
  input  logic                  m_hready
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  // State names the address phase currently on the bus; LAST_DATA and
  // ERR_WAIT only have a data phase outstanding.
  typedef enum logic [2:0] {
    S_IDLE, S_CTRL_OFF, S_BASE, S_MASK, S_CTRL_ON, S_LAST_DATA, S_ERR_WAIT
  } state_t;

  state_t                  state;
  logic [1:0]              htrans_q;
  logic [ADDR_WIDTH-1:0]   haddr_q;
  logic [DATA_WIDTH-1:0]   hwdata_q;

  // Data-phase tracking: valid, ctrl-write flag and enable byte to commit
  logic                    vld_p1;
  logic                    ctrl_p1;
  logic [7:0]              val_p1;

  // Captured command (data only, no reset needed)
  logic                    port_q;
  logic [2:0]              idx_q;
  logic [31:0]             base_q;
  logic [31:0]             mask_q;
  logic                    en_q;

  logic                    accept;
  logic                    resp_err;
  logic [7:0]              shadow_cmd;
  logic [7:0]              shadow_q;
  logic [7:0]              off_val;
  logic [7:0]              on_val;

  function automatic logic [ADDR_WIDTH-1:0] ctrl_addr(input logic port);
    return CFG_BASE + ADDR_WIDTH'({port, 2'b00});
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] base_addr(input logic port, input logic [2:0] idx);
    return CFG_BASE + ADDR_WIDTH'(8'h10) + ADDR_WIDTH'({port, 6'b0}) + ADDR_WIDTH'({idx, 3'b0});
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] mask_addr(input logic port, input logic [2:0] idx);
    return base_addr(port, idx) + ADDR_WIDTH'(4);
  endfunction

  function automatic logic [7:0] set_bit(input logic [7:0] v, input logic [2:0] idx, input logic b);
    logic [7:0] r;
    r      = v;
    r[idx] = b;
    return r;
  endfunction

  assign cmd_ready  = (state == S_IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign shadow_cmd = cmd_port ? en_1 : en_0;
  assign shadow_q   = port_q ? en_1 : en_0;
  assign off_val    = set_bit(shadow_q, idx_q, 1'b0);
  assign on_val     = set_bit(shadow_q, idx_q, en_q);
  assign resp_err   = vld_p1 && (m_hresp != HRESP_OKAY);

  // An error response cancels the pending address phase in the same cycle
  assign m_htrans = resp_err ? HTRANS_IDLE : htrans_q;
  assign m_hsel   = (m_htrans == HTRANS_NONSEQ);
  assign m_haddr  = haddr_q;
  assign m_hwdata = hwdata_q;
  assign m_hprot  = 4'b0011;
  assign m_hsize  = 3'b010;
  assign m_hburst = 3'b000;
  assign m_hwrite = 1'b1;

  // Capture command fields on accept; inputs are free to change afterwards
  always_ff @(posedge hclk) begin
    if (accept) begin
      port_q <= cmd_port;
      idx_q  <= cmd_idx;
      base_q <= cmd_base;
      mask_q <= cmd_mask;
      en_q   <= cmd_en;
    end
  end

  // Sequencer: advances address/data phases on hready, commits shadows on OKAY ctrl data
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state    <= S_IDLE;
      htrans_q <= HTRANS_IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      vld_p1   <= 1'b0;
      ctrl_p1  <= 1'b0;
      val_p1   <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      en_0     <= 8'h00;
      en_1     <= 8'h00;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            busy     <= 1'b1;
            htrans_q <= HTRANS_NONSEQ;
            vld_p1   <= 1'b0;
            if (shadow_cmd[cmd_idx]) begin
              state   <= S_CTRL_OFF;
              haddr_q <= ctrl_addr(cmd_port);
            end else begin
              state   <= S_BASE;
              haddr_q <= base_addr(cmd_port, cmd_idx);
            end
          end
        end
        S_ERR_WAIT: begin
          if (m_hready) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          if (resp_err) begin
            htrans_q <= HTRANS_IDLE;
            vld_p1   <= 1'b0;
            if (m_hready) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_ERR_WAIT;
            end
          end else if (m_hready) begin
            if (vld_p1 && ctrl_p1) begin
              if (port_q) en_1 <= val_p1;
              else        en_0 <= val_p1;
            end
            case (state)
              S_CTRL_OFF: begin
                hwdata_q <= DATA_WIDTH'(off_val);
                vld_p1   <= 1'b1;
                ctrl_p1  <= 1'b1;
                val_p1   <= off_val;
                haddr_q  <= base_addr(port_q, idx_q);
                state    <= S_BASE;
              end
              S_BASE: begin
                hwdata_q <= DATA_WIDTH'(base_q);
                vld_p1   <= 1'b1;
                ctrl_p1  <= 1'b0;
                haddr_q  <= mask_addr(port_q, idx_q);
                state    <= S_MASK;
              end
              S_MASK: begin
                hwdata_q <= DATA_WIDTH'(mask_q);
                vld_p1   <= 1'b1;
                ctrl_p1  <= 1'b0;
                haddr_q  <= ctrl_addr(port_q);
                state    <= S_CTRL_ON;
              end
              S_CTRL_ON: begin
                hwdata_q <= DATA_WIDTH'(on_val);
                vld_p1   <= 1'b1;
                ctrl_p1  <= 1'b1;
                val_p1   <= on_val;
                htrans_q <= HTRANS_IDLE;
                state    <= S_LAST_DATA;
              end
              default: begin
                vld_p1 <= 1'b0;
                done   <= 1'b1;
                busy   <= 1'b0;
                state  <= S_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
